tag_response_reader: RTL and testbench

//   Multiple-response resolver on the read side of the tag register array.

---
 rtl/tag_response_reader_if.sv | 38 +++
 rtl/tag_response_reader.sv | 106 ++++++++++
 tb/tb_tag_response_reader.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/tag_response_reader_if.sv
// Tag-enumeration bundle: tag snapshot source, start/abort control, status and response handshake.
// Optional resp_count member exists only when TAG_READER_COUNT_EN is defined.
interface tag_response_reader_if #(
    parameter int num_cells = 100,
    parameter int addr_bits = 7
);
    logic [num_cells-1:0] tag_wires;
    logic                 start;
    logic                 abort;
    logic                 busy;
    logic                 resp_valid;
    logic                 resp_ready;
    logic [addr_bits-1:0] resp_index;
    logic                 resp_last;
    logic                 done;
    logic                 none;
`ifdef TAG_READER_COUNT_EN
    logic [addr_bits:0]   resp_count;

    modport master (
        input  tag_wires, start, abort, resp_ready,
        output busy, resp_valid, resp_index, resp_last, done, none, resp_count
    );
    modport slave (
        output tag_wires, start, abort, resp_ready,
        input  busy, resp_valid, resp_index, resp_last, done, none, resp_count
    );
`else
    modport master (
        input  tag_wires, start, abort, resp_ready,
        output busy, resp_valid, resp_index, resp_last, done, none
    );
    modport slave (
        output tag_wires, start, abort, resp_ready,
        input  busy, resp_valid, resp_index, resp_last, done, none
    );
`endif
endinterface

// File: rtl/tag_response_reader.sv
// Snapshots the tag vector on start and streams every set index, lowest first (optional resp_count via TAG_READER_COUNT_EN).
// Latency: first index valid the cycle after the start edge; one index per cycle while ready, done pulses after the last.
// Backpressure: resp_ready low holds resp_index/resp_last and pending stable; abort drops the rest without a done pulse.
module tag_response_reader #(
    parameter int num_cells = 100,
    parameter int addr_bits = 7
) (
    input  logic                    clk,
    input  logic                    rst_n,
    tag_response_reader_if.master   bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [num_cells-1:0] ONE = num_cells'(1);

    state_t               state;
    state_t               state_nxt;
    logic [num_cells-1:0] pending;
    logic                 none_q;
    logic [addr_bits-1:0] low_idx;
    logic                 one_left;
    logic                 hs;

    // Bit 0 has the highest priority, so the downward scan leaves the lowest set index.
    always_comb begin
        low_idx = '0;
        for (int i = num_cells - 1; i >= 0; i--) begin
            if (pending[i]) low_idx = addr_bits'(i);
        end
    end

    assign one_left = (pending != '0) && ((pending & (pending - ONE)) == '0);
    assign hs       = (state == SCAN) && bus.resp_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (bus.start) state_nxt = (bus.tag_wires != '0) ? SCAN : DONE;
            SCAN: begin
                if (bus.abort)          state_nxt = IDLE;
                else if (hs && one_left) state_nxt = DONE;
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        bus.busy       = (state == SCAN);
        bus.resp_valid = (state == SCAN);
        bus.resp_index = low_idx;
        bus.resp_last  = (state == SCAN) && one_left;
        bus.done       = (state == DONE);
        bus.none       = none_q;
    end

    // Handshake retires the lowest set bit: pending & (pending - 1).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending <= '0;
            none_q  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        pending <= bus.tag_wires;
                        none_q  <= (bus.tag_wires == '0);
                    end
                end
                SCAN: begin
                    none_q <= 1'b0;
                    if (bus.abort)   pending <= '0;
                    else if (hs)     pending <= pending & (pending - ONE);
                end
                default: none_q <= 1'b0;
            endcase
        end
    end

`ifdef TAG_READER_COUNT_EN
    logic [addr_bits:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (state == IDLE && bus.start) begin
            count <= '0;
        end else if (hs && !bus.abort) begin
            count <= count + 1'b1;
        end
    end

    assign bus.resp_count = count;
`endif

endmodule

// File: tb/tb_tag_response_reader.sv
// Randomized bench for tag_response_reader (8 cells); expected index order comes from a per-run queue of set tag bits.
module tb_tag_response_reader;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    tag_response_reader_if #(.num_cells(8), .addr_bits(3)) bus ();

    tag_response_reader #(.num_cells(8), .addr_bits(3)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic test_reset();
        checks++;
        if (bus.busy !== 1'b0 || bus.resp_valid !== 1'b0 || bus.done !== 1'b0 ||
            bus.none !== 1'b0 || bus.resp_last !== 1'b0 || bus.resp_index !== 3'd0) begin
            errors++;
            $display("FAIL reset_outputs got busy=%b vld=%b done=%b none=%b last=%b idx=%0d exp all 0",
                     bus.busy, bus.resp_valid, bus.done, bus.none, bus.resp_last, bus.resp_index);
        end
`ifdef TAG_READER_COUNT_EN
        checks++;
        if (bus.resp_count !== 4'd0) begin
            errors++;
            $display("FAIL reset_count got %0d exp 0", bus.resp_count);
        end
`endif
    endtask

    // Called at a negedge in IDLE; returns at the negedge after the start edge.
    task automatic do_start(input logic [7:0] tags, input bit with_abort);
        bus.tag_wires = tags;
        bus.start     = 1'b1;
        bus.abort     = with_abort;
        @(negedge clk);
        bus.start     = 1'b0;
        bus.abort     = 1'b0;
        bus.tag_wires = ~tags;
    endtask

    // Checks the whole enumeration of tags from the cycle after start through the return to IDLE.
    task automatic drain(input logic [7:0] tags, input bit rnd_ready, input bit noise);
        int q[$];
        int n;
        int budget;
        bit rdy;
        n = 0;
        budget = 0;
        for (int i = 0; i < 8; i++) if (tags[i]) q.push_back(i);
        if (q.size() == 0) begin
            checks++;
            if (bus.resp_valid !== 1'b0 || bus.busy !== 1'b0 || bus.done !== 1'b1 || bus.none !== 1'b1) begin
                errors++;
                $display("FAIL empty_done got vld=%b busy=%b done=%b none=%b exp 0 0 1 1",
                         bus.resp_valid, bus.busy, bus.done, bus.none);
            end
        end else begin
            while (q.size() > 0 && budget < 200) begin
                checks++;
                if (bus.resp_valid !== 1'b1 || bus.busy !== 1'b1 || bus.done !== 1'b0) begin
                    errors++;
                    $display("FAIL scan_status got vld=%b busy=%b done=%b exp 1 1 0",
                             bus.resp_valid, bus.busy, bus.done);
                end
                checks++;
                if (bus.resp_index !== 3'(q[0])) begin
                    errors++;
                    $display("FAIL resp_index got %0d exp %0d", bus.resp_index, q[0]);
                end
                checks++;
                if (bus.resp_last !== (q.size() == 1)) begin
                    errors++;
                    $display("FAIL resp_last got %b exp %b (idx %0d)", bus.resp_last, q.size() == 1, q[0]);
                end
                rdy = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
                bus.resp_ready = rdy;
                if (noise) begin
                    bus.start     = 1'($urandom_range(0, 1));
                    bus.tag_wires = 8'($urandom);
                end
                if (rdy) begin
                    void'(q.pop_front());
                    n++;
                end
                @(negedge clk);
                budget++;
            end
            checks++;
            if (budget >= 200) begin
                errors++;
                $display("FAIL drain_timeout got %0d cycles exp < 200", budget);
            end
            checks++;
            if (bus.done !== 1'b1 || bus.none !== 1'b0 || bus.resp_valid !== 1'b0) begin
                errors++;
                $display("FAIL done_pulse got done=%b none=%b vld=%b exp 1 0 0",
                         bus.done, bus.none, bus.resp_valid);
            end
        end
        bus.start      = 1'b0;
        bus.resp_ready = 1'b0;
`ifdef TAG_READER_COUNT_EN
        checks++;
        if (bus.resp_count !== 4'(n)) begin
            errors++;
            $display("FAIL resp_count got %0d exp %0d", bus.resp_count, n);
        end
`endif
        @(negedge clk);
        checks++;
        if (bus.done !== 1'b0 || bus.busy !== 1'b0 || bus.none !== 1'b0 || bus.resp_valid !== 1'b0) begin
            errors++;
            $display("FAIL back_to_idle got done=%b busy=%b none=%b vld=%b exp all 0",
                     bus.done, bus.busy, bus.none, bus.resp_valid);
        end
    endtask

    task automatic test_basic();
        do_start(8'b1010_0100, 1'b0);
        drain(8'b1010_0100, 1'b0, 1'b0);
        do_start(8'b0110_1001, 1'b0);
        drain(8'b0110_1001, 1'b0, 1'b0);
    endtask

    task automatic test_empty();
        do_start(8'h00, 1'b0);
        drain(8'h00, 1'b0, 1'b0);
    endtask

    task automatic test_stall();
        do_start(8'b0000_0011, 1'b0);
        bus.resp_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (bus.resp_valid !== 1'b1 || bus.resp_index !== 3'd0 || bus.resp_last !== 1'b0) begin
                errors++;
                $display("FAIL stall_hold got vld=%b idx=%0d last=%b exp 1 0 0",
                         bus.resp_valid, bus.resp_index, bus.resp_last);
            end
            @(negedge clk);
        end
        drain(8'b0000_0011, 1'b0, 1'b0);
    endtask

    task automatic test_abort();
        do_start(8'hFF, 1'b0);
        bus.resp_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (bus.resp_index !== 3'(i)) begin
                errors++;
                $display("FAIL abort_pre_idx got %0d exp %0d", bus.resp_index, i);
            end
            if (i == 2) bus.abort = 1'b1;
            @(negedge clk);
        end
        bus.abort      = 1'b0;
        bus.resp_ready = 1'b0;
        checks++;
        if (bus.busy !== 1'b0 || bus.resp_valid !== 1'b0 || bus.done !== 1'b0) begin
            errors++;
            $display("FAIL abort_idle got busy=%b vld=%b done=%b exp 0 0 0",
                     bus.busy, bus.resp_valid, bus.done);
        end
`ifdef TAG_READER_COUNT_EN
        checks++;
        if (bus.resp_count !== 4'd2) begin
            errors++;
            $display("FAIL abort_count got %0d exp 2", bus.resp_count);
        end
`endif
        @(negedge clk);
        checks++;
        if (bus.done !== 1'b0) begin
            errors++;
            $display("FAIL abort_no_done got %b exp 0", bus.done);
        end
        do_start(8'h80, 1'b1);
        drain(8'h80, 1'b0, 1'b0);
    endtask

    task automatic test_async_reset();
        do_start(8'hFF, 1'b0);
        bus.resp_ready = 1'b1;
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (bus.busy !== 1'b0 || bus.resp_valid !== 1'b0 || bus.done !== 1'b0 ||
            bus.none !== 1'b0 || bus.resp_last !== 1'b0 || bus.resp_index !== 3'd0) begin
            errors++;
            $display("FAIL async_reset got busy=%b vld=%b done=%b none=%b last=%b idx=%0d exp all 0",
                     bus.busy, bus.resp_valid, bus.done, bus.none, bus.resp_last, bus.resp_index);
        end
        bus.resp_ready = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL post_reset got done=%b busy=%b exp 0 0", bus.done, bus.busy);
        end
        do_start(8'b0100_0010, 1'b0);
        drain(8'b0100_0010, 1'b0, 1'b0);
    endtask

    task automatic test_random();
        logic [7:0] t;
        for (int k = 0; k < 30; k++) begin
            t = ($urandom_range(0, 4) == 0) ? 8'h00 : 8'($urandom);
            do_start(t, 1'($urandom_range(0, 1)));
            drain(t, 1'b1, 1'b1);
        end
    endtask

    initial begin
        checks         = 0;
        errors         = 0;
        rst_n          = 1'b0;
        bus.tag_wires  = '0;
        bus.start      = 1'b0;
        bus.abort      = 1'b0;
        bus.resp_ready = 1'b0;
        #12;
        test_reset();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        test_basic();
        test_empty();
        test_stall();
        test_abort();
        test_async_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
